// File: rtl/counter_cmd_driver.sv
// Command driver for an external up/down/load counter. Turns accepted
// commands into one-cycle strobes and checks the counter against a shadow model.
module counter_cmd_driver #(
  parameter int W     = 8,
  parameter int WRAPW = 16
) (
  input  logic             clk,
  input  logic             srst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [W-1:0]     cmd_arg,
  output logic             load,
  output logic             up,
  output logic             down,
  output logic [W-1:0]     data,
  input  logic [W-1:0]     count,
  input  logic             rollover,
  output logic             done,
  output logic [W-1:0]     exp_count,
  output logic [WRAPW-1:0] wrap_cnt,
  output logic             mismatch,
  output logic [1:0]       state_dbg
);

  // Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, and cmd_* are not looked at otherwise.
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DOWN = 2'b11;

  state_t           state_q, state_d;
  logic [W-1:0]     arg_q, arg_d;
  logic [W-1:0]     remain_q, remain_d;
  logic             dir_down_q, dir_down_d;
  logic             load_q, load_d;
  logic             up_q, up_d;
  logic             down_q, down_d;
  logic [W-1:0]     data_q, data_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic [W-1:0]     exp_q, exp_d;
  logic [WRAPW-1:0] wrap_q, wrap_d;
  logic             mismatch_q, mismatch_d;

  always_comb begin
    state_d    = state_q;
    arg_d      = arg_q;
    remain_d   = remain_q;
    dir_down_d = dir_down_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD: begin
              arg_d   = cmd_arg;
              state_d = S_LOAD;
            end
            OP_UP, OP_DOWN: begin
              dir_down_d = (cmd_op == OP_DOWN);
              remain_d   = cmd_arg;
              state_d    = (cmd_arg != '0) ? S_RUN : S_DONE;
            end
            OP_NOP:  state_d = S_DONE;
            default: state_d = S_DONE;
          endcase
        end
      end
      S_LOAD: state_d = S_DONE;
      S_RUN: begin
        remain_d = remain_q - 1'b1;
        if (remain_q == {{(W-1){1'b0}}, 1'b1}) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are flops loaded from the next state, so they align with it.
    load_d  = (state_d == S_LOAD);
    data_d  = load_d ? arg_d : '0;
    up_d    = (state_d == S_RUN) && !dir_down_d;
    down_d  = (state_d == S_RUN) && dir_down_d;
    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE);
  end

  // Shadow counter moves on the same edge the real counter sees the strobe.
  always_comb begin
    exp_d  = exp_q;
    wrap_d = wrap_q;
    if (load_q)      exp_d = data_q;
    else if (up_q)   exp_d = exp_q + 1'b1;
    else if (down_q) exp_d = exp_q - 1'b1;
    if (((up_q && (&exp_q)) || (down_q && (exp_q == '0))) && !(&wrap_q))
      wrap_d = wrap_q + 1'b1;
    mismatch_d = mismatch_q | (count != exp_q) | (rollover != (&exp_q));
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q    <= S_IDLE;
      arg_q      <= '0;
      remain_q   <= '0;
      dir_down_q <= 1'b0;
      load_q     <= 1'b0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
      exp_q      <= '0;
      wrap_q     <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      arg_q      <= arg_d;
      remain_q   <= remain_d;
      dir_down_q <= dir_down_d;
      load_q     <= load_d;
      up_q       <= up_d;
      down_q     <= down_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      exp_q      <= exp_d;
      wrap_q     <= wrap_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign cmd_ready = ready_q;
  assign load      = load_q;
  assign up        = up_q;
  assign down      = down_q;
  assign data      = data_q;
  assign done      = done_q;
  assign exp_count = exp_q;
  assign wrap_cnt  = wrap_q;
  assign mismatch  = mismatch_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_counter_cmd_driver.sv
// Bench for counter_cmd_driver: a behavioural counter with fault injection,
// randomized commands, and an arithmetic model of count and wrap totals.
module tb_counter_cmd_driver;

  localparam int W     = 8;
  localparam int WRAPW = 16;
  localparam logic [1:0] OP_NOP = 2'b00, OP_LOAD = 2'b01, OP_UP = 2'b10, OP_DOWN = 2'b11;

  logic             clk, srst_n, cmd_valid, cmd_ready;
  logic [1:0]       cmd_op;
  logic [W-1:0]     cmd_arg;
  logic             load, up, down, done, rollover, mismatch;
  logic [W-1:0]     data, count, exp_count, cnt_q;
  logic [WRAPW-1:0] wrap_cnt;
  logic [1:0]       state_dbg;
  logic             fault_en;

  int checks = 0;
  int errors = 0;

  // Model state: counter value, wrap total, expected sticky error.
  int   model_count;
  int   model_wraps;
  logic model_mm;

  // Observations from the last command.
  int           r_lat, r_load, r_up, r_down, r_bad;
  logic [W-1:0] r_ldata;
  logic [W-1:0] obs_cnt[$];
  logic         obs_roll[$];

  counter_cmd_driver #(.W(W), .WRAPW(WRAPW)) dut (
    .clk(clk), .srst_n(srst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .load(load), .up(up), .down(down),
    .data(data), .count(count), .rollover(rollover), .done(done),
    .exp_count(exp_count), .wrap_cnt(wrap_cnt), .mismatch(mismatch),
    .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External counter sharing the reset.
  always @(posedge clk) begin
    if (!srst_n)   cnt_q <= '0;
    else if (load) cnt_q <= data;
    else if (up)   cnt_q <= cnt_q + 1'b1;
    else if (down) cnt_q <= cnt_q - 1'b1;
  end
  assign count    = fault_en ? (cnt_q ^ 8'h01) : cnt_q;
  assign rollover = &cnt_q;

  function automatic int exp_lat(input logic [1:0] op, input int arg);
    if (op == OP_LOAD) return 2;
    if (op == OP_NOP || arg == 0) return 1;
    return arg + 1;
  endfunction

  task automatic model_apply(input logic [1:0] op, input int arg);
    if (op == OP_LOAD) model_count = arg;
    else if (op == OP_UP) begin
      model_wraps += (model_count + arg) / 256;
      model_count  = (model_count + arg) % 256;
    end else if (op == OP_DOWN) begin
      if (arg > model_count) model_wraps += (arg - model_count - 1) / 256 + 1;
      model_count = ((model_count - arg) % 256 + 256) % 256;
    end
    if (model_wraps > 65535) model_wraps = 65535;
  endtask

  task automatic do_reset();
    @(negedge clk);
    srst_n = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    srst_n = 1'b1;
    model_count = 0;
    model_wraps = 0;
    model_mm    = 1'b0;
  endtask

  // Issue one command from IDLE and record what the DUT does until done.
  task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] arg, input bit hold);
    r_lat = -1; r_load = 0; r_up = 0; r_down = 0; r_bad = 0; r_ldata = '0;
    obs_cnt.delete();
    obs_roll.delete();
    @(negedge clk);
    if (!cmd_ready) r_bad++;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (hold) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_arg   = 8'($urandom_range(0, 255));
      end else cmd_valid = 1'b0;
      if (c > 1) begin
        obs_cnt.push_back(count);
        obs_roll.push_back(rollover);
      end
      if (int'(load) + int'(up) + int'(down) > 1) r_bad++;
      if (!load && data !== '0) r_bad++;
      if (cmd_ready) r_bad++;
      r_load += int'(load);
      r_up   += int'(up);
      r_down += int'(down);
      if (load) r_ldata = data;
      if (done) begin
        r_lat = c;
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [W+WRAPW+W+5:0] got, want;
    @(negedge clk);
    srst_n = 1'b0;
    @(negedge clk);
    got  = {cmd_ready, load, up, down, done, data, exp_count, wrap_cnt, mismatch};
    want = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 1'b0};
    checks++;
    if (got !== want) begin errors++; $display("FAIL reset_outputs: got %h expected %h", got, want); end
    srst_n = 1'b1;
    model_count = 0; model_wraps = 0; model_mm = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== exp_count || mismatch !== 1'b0) begin
      errors++; $display("FAIL reset_agree: count %h exp_count %h mismatch %b", count, exp_count, mismatch);
    end
  endtask

  task automatic test_load();
    do_reset();
    run_cmd(OP_LOAD, 8'h5A, 1'b0);
    model_apply(OP_LOAD, 'h5A);
    checks++;
    if (r_lat !== 2) begin errors++; $display("FAIL load_latency: got %0d expected 2", r_lat); end
    checks++;
    if (r_load !== 1 || r_ldata !== 8'h5A || r_up !== 0 || r_down !== 0 || r_bad !== 0) begin
      errors++; $display("FAIL load_strobe: loads %0d data %h ups %0d downs %0d bad %0d expected 1 5a 0 0 0",
                         r_load, r_ldata, r_up, r_down, r_bad);
    end
    checks++;
    if (count !== 8'(model_count) || exp_count !== 8'(model_count) || mismatch !== 1'b0) begin
      errors++; $display("FAIL load_count: count %h exp_count %h mismatch %b expected %h", count, exp_count, mismatch, 8'(model_count));
    end
  endtask

  task automatic test_up_wrap();
    logic [W-1:0] want_cnt;
    do_reset();
    run_cmd(OP_LOAD, 8'hFE, 1'b0);
    model_apply(OP_LOAD, 'hFE);
    run_cmd(OP_UP, 8'd3, 1'b0);
    checks++;
    if (r_lat !== 4 || r_up !== 3 || r_down !== 0 || r_load !== 0 || r_bad !== 0) begin
      errors++; $display("FAIL up_strobe: lat %0d ups %0d downs %0d loads %0d bad %0d expected 4 3 0 0 0",
                         r_lat, r_up, r_down, r_load, r_bad);
    end
    for (int i = 0; i < 3; i++) begin
      want_cnt = 8'((model_count + i + 1) % 256);
      checks++;
      if (obs_cnt.size() <= i || obs_cnt[i] !== want_cnt || obs_roll[i] !== (want_cnt == 8'hFF)) begin
        errors++; $display("FAIL up_seq[%0d]: got count %h roll %b expected %h %b", i,
                           (obs_cnt.size() > i) ? obs_cnt[i] : 8'hxx, (obs_roll.size() > i) ? obs_roll[i] : 1'bx,
                           want_cnt, want_cnt == 8'hFF);
      end
    end
    model_apply(OP_UP, 3);
    checks++;
    if (wrap_cnt !== 16'(model_wraps)) begin errors++; $display("FAIL up_wrap: got %0d expected %0d", wrap_cnt, model_wraps); end
  endtask

  task automatic test_down_wrap();
    do_reset();
    run_cmd(OP_LOAD, 8'h01, 1'b0);
    model_apply(OP_LOAD, 1);
    run_cmd(OP_DOWN, 8'd2, 1'b0);
    checks++;
    if (r_lat !== 3 || r_down !== 2 || r_up !== 0 || obs_cnt.size() !== 2) begin
      errors++; $display("FAIL down_strobe: lat %0d downs %0d ups %0d samples %0d expected 3 2 0 2", r_lat, r_down, r_up, obs_cnt.size());
    end else begin
      checks++;
      if (obs_cnt[0] !== 8'h00 || obs_cnt[1] !== 8'hFF) begin
        errors++; $display("FAIL down_seq: got %h %h expected 00 ff", obs_cnt[0], obs_cnt[1]);
      end
    end
    model_apply(OP_DOWN, 2);
    checks++;
    if (wrap_cnt !== 16'(model_wraps)) begin errors++; $display("FAIL down_wrap: got %0d expected %0d", wrap_cnt, model_wraps); end
    run_cmd(OP_UP, 8'd0, 1'b0);
    checks++;
    if (r_lat !== 1 || r_up !== 0 || r_down !== 0 || r_load !== 0) begin
      errors++; $display("FAIL up_zero: lat %0d strobes %0d expected 1 0", r_lat, r_up + r_down + r_load);
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    @(negedge clk);
    fault_en = 1'b1;
    @(negedge clk);
    fault_en = 1'b0;
    checks++;
    if (mismatch !== 1'b1) begin errors++; $display("FAIL mismatch_set: got %b expected 1", mismatch); end
    run_cmd(OP_LOAD, 8'h33, 1'b0);
    model_apply(OP_LOAD, 'h33);
    run_cmd(OP_UP, 8'd2, 1'b0);
    model_apply(OP_UP, 2);
    checks++;
    if (mismatch !== 1'b1 || r_lat !== 3 || exp_count !== 8'(model_count)) begin
      errors++; $display("FAIL mismatch_sticky: mismatch %b lat %0d exp_count %h expected 1 3 %h", mismatch, r_lat, exp_count, 8'(model_count));
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (mismatch !== 1'b0) begin errors++; $display("FAIL mismatch_clear: got %b expected 0", mismatch); end
  endtask

  task automatic test_reset_mid_run();
    int seen_done, seen_up;
    do_reset();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_UP; cmd_arg = 8'd10;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (up !== 1'b1 || count !== 8'd3) begin errors++; $display("FAIL mid_run_step4: up %b count %h expected 1 03", up, count); end
    srst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, load, up, down, done, data, exp_count, wrap_cnt, mismatch, count} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 1'b0, 8'h00}) begin
      errors++; $display("FAIL mid_run_reset: ready %b load %b up %b down %b done %b data %h exp %h wrap %0d mm %b count %h",
                         cmd_ready, load, up, down, done, data, exp_count, wrap_cnt, mismatch, count);
    end
    srst_n = 1'b1;
    model_count = 0; model_wraps = 0; model_mm = 1'b0;
    seen_done = 0; seen_up = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen_done += int'(done);
      seen_up   += int'(up);
    end
    checks++;
    if (seen_done !== 0 || seen_up !== 0) begin errors++; $display("FAIL mid_run_abandon: done %0d up %0d expected 0 0", seen_done, seen_up); end
    run_cmd(OP_LOAD, 8'h10, 1'b0);
    model_apply(OP_LOAD, 'h10);
    checks++;
    if (r_lat !== 2 || count !== 8'h10 || exp_count !== 8'h10) begin
      errors++; $display("FAIL mid_run_reload: lat %0d count %h exp %h expected 2 10 10", r_lat, count, exp_count);
    end
  endtask

  task automatic test_ignore_busy();
    do_reset();
    run_cmd(OP_LOAD, 8'h80, 1'b0);
    model_apply(OP_LOAD, 'h80);
    run_cmd(OP_UP, 8'd5, 1'b1);
    model_apply(OP_UP, 5);
    checks++;
    if (r_lat !== 6 || r_up !== 5 || r_down !== 0 || r_load !== 0 || r_bad !== 0 || count !== 8'(model_count)) begin
      errors++; $display("FAIL ignore_busy: lat %0d ups %0d downs %0d loads %0d bad %0d count %h expected 6 5 0 0 0 %h",
                         r_lat, r_up, r_down, r_load, r_bad, count, 8'(model_count));
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_done: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_random();
    logic [1:0]   op;
    logic [W-1:0] arg;
    int           want_up, want_down, want_load;
    do_reset();
    for (int k = 0; k < 30; k++) begin
      op  = 2'($urandom_range(0, 3));
      arg = (op == OP_UP || op == OP_DOWN) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
      run_cmd(op, arg, bit'($urandom_range(0, 1)));
      model_apply(op, int'(arg));
      want_load = (op == OP_LOAD) ? 1 : 0;
      want_up   = (op == OP_UP) ? int'(arg) : 0;
      want_down = (op == OP_DOWN) ? int'(arg) : 0;
      checks++;
      if (r_lat !== exp_lat(op, int'(arg)) || r_load !== want_load || r_up !== want_up ||
          r_down !== want_down || r_bad !== 0 || (op == OP_LOAD && r_ldata !== arg)) begin
        errors++; $display("FAIL rand_cmd[%0d] op %0d arg %0d: lat %0d ld %0d up %0d dn %0d bad %0d expected %0d %0d %0d %0d 0",
                           k, op, arg, r_lat, r_load, r_up, r_down, r_bad, exp_lat(op, int'(arg)), want_load, want_up, want_down);
      end
      checks++;
      if (count !== 8'(model_count) || exp_count !== 8'(model_count) || wrap_cnt !== 16'(model_wraps) || mismatch !== model_mm) begin
        errors++; $display("FAIL rand_state[%0d]: count %h exp %h wrap %0d mm %b expected %h %0d %b",
                           k, count, exp_count, wrap_cnt, mismatch, 8'(model_count), model_wraps, model_mm);
      end
    end
  endtask

  initial begin
    srst_n    = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_arg   = '0;
    fault_en  = 1'b0;
    model_count = 0; model_wraps = 0; model_mm = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_load();
    test_up_wrap();
    test_down_wrap();
    test_mismatch();
    test_reset_mid_run();
    test_ignore_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_cmd_driver.md
COUNTER_CMD_DRIVER -- requirements
Module: counter_cmd_driver

Interface
REQ-001 Parameter: W, default 8, width of counter data/count.
REQ-002 Parameter: WRAPW, default 16, width of wrap counter.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 srst_n  input  1  reset, synchronous, active-low.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-007 cmd_op  input  2  00 NOP, 01 LOAD, 10 UP, 11 DOWN.
REQ-008 cmd_arg  input  W  LOAD: value to load; UP/DOWN: step count n; NOP: ignored.
REQ-009 load  output  1  load strobe to counter.
REQ-010 up  output  1  increment strobe to counter.
REQ-011 down  output  1  decrement strobe to counter.
REQ-012 data  output  W  load value to counter.
REQ-013 count  input  W  counter value, registered in counter, updates on edge after strobe.
REQ-014 rollover  input  1  counter flag, expected == &count.
REQ-015 done  output  1  one-cycle pulse: command complete.
REQ-016 exp_count  output  W  reference model of counter value.
REQ-017 wrap_cnt  output  WRAPW  number of wraps (up from all-ones or down from 0), saturating.
REQ-018 mismatch  output  1  sticky error: count or rollover disagreed with model.

Function
REQ-019 FSM states IDLE, LOAD, RUN, DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-020 IDLE: on accept, LOAD op -> LOAD (arg latched); UP/DOWN with n>0 -> RUN (n, direction latched); UP/DOWN with n=0 or NOP -> DONE.
REQ-021 LOAD: load=1, data=latched arg for exactly one cycle, then DONE.
REQ-022 RUN: up (or down) =1 for exactly n consecutive cycles, remaining count decremented each cycle, then DONE.
REQ-023 DONE: done=1 for one cycle, then IDLE; next accept possible the cycle after DONE.
REQ-024 load, up, down, data SHALL be decoded from registered state only; no combinational path from cmd_* to them.
REQ-025 At most one of load/up/down SHALL be 1 in any cycle; data SHALL be 0 when load=0.
REQ-026 exp_count SHALL update on the same edge the counter acts: load -> data; up -> +1 mod 2^W; down -> -1 mod 2^W; else hold.
REQ-027 wrap_cnt SHALL increment on up with exp_count all-ones, or down with exp_count 0; holds at 2^WRAPW-1.
REQ-028 Check every cycle with srst_n=1: count != exp_count or rollover != &exp_count SHALL set mismatch next edge.
REQ-029 mismatch SHALL stay 1 until reset; FSM operation unaffected by mismatch.
REQ-030 cmd_valid while cmd_ready=0 SHALL be ignored (cmd_* not sampled).
REQ-031 Latency: LOAD accept to done = 2 cycles; UP/DOWN n accept to done = n+1 cycles; NOP or n=0 = 1 cycle.

Reset
REQ-032 srst_n=0 at an edge SHALL force IDLE, load=up=down=0, data=0, done=0, exp_count=0, wrap_cnt=0, mismatch=0, cmd_ready=1 after that edge.
REQ-033 Reset mid-LOAD or mid-RUN SHALL abandon the command with no done pulse; remaining steps discarded.
REQ-034 Counter shares srst_n, so exp_count=0 and count=0 agree immediately after reset.

Verification
REQ-035 W=8: LOAD 0x5A -> load=1/data=0x5A one cycle, done 2 cycles after accept, count=exp_count=0x5A, mismatch=0.
REQ-036 LOAD 0xFE, UP 3 -> up high 3 cycles, count 0xFF,0x00,0x01; rollover=1 at 0xFF only; wrap_cnt=1.
REQ-037 LOAD 0x01, DOWN 2 -> count 0x00,0xFF; wrap_cnt=1; then UP 0 -> done 1 cycle after accept, no strobe.
REQ-038 Force count to differ from model for one cycle (faulty counter stub) -> mismatch=1 next edge and stays 1 through further commands until reset.
REQ-039 Assert srst_n=0 during UP 10 at step 4 -> no done, all outputs reset, cmd_ready=1; new LOAD 0x10 completes normally.
REQ-040 Hold cmd_valid during RUN with changing cmd_op -> ignored; only accepted in IDLE.
